// File: rtl/mac_dot_engine.sv
// mac_dot_engine: handshaked unsigned multiply-accumulate dot product.
// One result per LEN accepted operand pairs, saturating or wrapping.
module mac_dot_engine #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10,
  parameter int LEN    = 4,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic                ovf;
  logic                ovf_nx;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic                accept;

  assign prod      = a * b;
  assign sum       = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign in_ready  = rst_n & ~clear & (state == ACC);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);
  assign result    = acc;
  assign overflow  = ovf;

  // next-state: clear beats handshakes; HOLD freezes acc until drained
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    if (clear) begin
      state_nx = ACC;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            if (sum[ACC_W]) begin
              ovf_nx = 1'b1;
              acc_nx = SAT ? '1 : sum[ACC_W-1:0];
            end else begin
              acc_nx = sum[ACC_W-1:0];
            end
            if (cnt == LAST) begin
              cnt_nx   = '0;
              state_nx = HOLD;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nx = ACC;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
          end
        end
        default: state_nx = ACC;
      endcase
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: directed plus random checks of three engine
// configurations against a sum-of-products reference model.
module tb_mac_dot_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv[3];
  logic       clr[3];
  logic       ordy[3];
  logic       irdy[3];
  logic       ovld[3];
  logic       ovf[3];
  logic [3:0] ia[3];
  logic [3:0] ib[3];
  logic [9:0] res[3];

  int total = 0;
  int bad = 0;

  int m_sum[3];
  int m_n[3];
  bit m_hold[3];

  mac_dot_engine #(.DATA_W(4), .ACC_W(10), .LEN(4), .SAT(1'b1)) u_len4 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .a(ia[0]), .b(ib[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]),
    .result(res[0]), .overflow(ovf[0])
  );

  mac_dot_engine #(.DATA_W(4), .ACC_W(10), .LEN(8), .SAT(1'b1)) u_sat8 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .a(ia[1]), .b(ib[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]),
    .result(res[1]), .overflow(ovf[1])
  );

  mac_dot_engine #(.DATA_W(4), .ACC_W(10), .LEN(8), .SAT(1'b0)) u_wrap8 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]),
    .in_valid(iv[2]), .in_ready(irdy[2]), .a(ia[2]), .b(ib[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]),
    .result(res[2]), .overflow(ovf[2])
  );

  function automatic int len_of(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic bit sat_of(int k);
    return k != 2;
  endfunction

  // visible accumulator: clipped or wrapped running total
  function automatic int exp_acc(int k);
    if (sat_of(k)) return (m_sum[k] > 1023) ? 1023 : m_sum[k];
    return m_sum[k] % 1024;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("in_ready%0d", k), 32'(irdy[k]),
          32'(rst_n && !clr[k] && !m_hold[k]));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clr[k]) begin
        m_sum[k]  = 0;
        m_n[k]    = 0;
        m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
        if (ordy[k]) begin
          m_hold[k] = 1'b0;
          m_sum[k]  = 0;
        end
      end else if (iv[k]) begin
        m_sum[k] += int'(ia[k]) * int'(ib[k]);
        m_n[k]++;
        if (m_n[k] == len_of(k)) begin
          m_n[k]    = 0;
          m_hold[k] = 1'b1;
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("result%0d", k), 32'(res[k]), 32'(exp_acc(k)));
      chk($sformatf("out_valid%0d", k), 32'(ovld[k]), 32'(m_hold[k]));
      chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_sum[k] >= 1024));
    end
  endtask

  task automatic put(int k, int av, int bv);
    iv[k] = 1'b1;
    ia[k] = 4'(av);
    ib[k] = 4'(bv);
    tick();
    iv[k] = 1'b0;
    ia[k] = 4'($urandom);
    ib[k] = 4'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
      ia[k] = '0; ib[k] = '0;
      m_sum[k] = 0; m_n[k] = 0; m_hold[k] = 1'b0;
    end
    // reset with a term presented
    iv[0] = 1'b1; ia[0] = 4'd15; ib[0] = 4'd15;
    tick();
    tick();
    chk("rst_res", 32'(res[0]), 0);
    chk("rst_vld", 32'(ovld[0]), 0);
    chk("rst_ovf", 32'(ovf[0]), 0);
    chk("rst_rdy", 32'(irdy[0]), 0);
    rst_n = 1'b1;
    iv[0] = 1'b0;
    #1;
    chk("rel_rdy", 32'(irdy[0]), 1);
    tick();
    chk("rel_acc", 32'(res[0]), 0);

    // basic dot product then backpressure
    ordy[0] = 1'b0;
    put(0, 3, 5);
    put(0, 2, 7);
    put(0, 15, 15);
    put(0, 1, 1);
    chk("basic_res", 32'(res[0]), 255);
    chk("basic_vld", 32'(ovld[0]), 1);
    chk("basic_ovf", 32'(ovf[0]), 0);
    chk("basic_rdy", 32'(irdy[0]), 0);
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      tick();
      chk("bp_res", 32'(res[0]), 255);
      chk("bp_vld", 32'(ovld[0]), 1);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    chk("drain_res", 32'(res[0]), 0);
    chk("drain_vld", 32'(ovld[0]), 0);
    chk("drain_rdy", 32'(irdy[0]), 1);

    // clear mid-transaction
    put(0, 4, 4);
    put(0, 2, 2);
    clr[0] = 1'b1;
    put(0, 9, 9);
    clr[0] = 1'b0;
    chk("clr_acc", 32'(res[0]), 0);
    put(0, 1, 2);
    put(0, 1, 3);
    put(0, 1, 4);
    put(0, 1, 5);
    chk("clr_res", 32'(res[0]), 14);
    chk("clr_vld", 32'(ovld[0]), 1);
    // clear in HOLD drops the result
    clr[0] = 1'b1;
    ordy[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("hclr_vld", 32'(ovld[0]), 0);
    chk("hclr_res", 32'(res[0]), 0);

    // bubbles between pairs
    put(0, 3, 5); tick(); tick();
    put(0, 2, 7); tick(); tick();
    put(0, 15, 15); tick(); tick();
    chk("bub_pre", 32'(ovld[0]), 0);
    put(0, 1, 1);
    chk("bub_res", 32'(res[0]), 255);
    chk("bub_vld", 32'(ovld[0]), 1);
    tick();

    // overflow: saturating and wrapping
    for (int i = 0; i < 8; i++) begin
      iv[1] = 1'b1; ia[1] = 4'd15; ib[1] = 4'd15;
      iv[2] = 1'b1; ia[2] = 4'd15; ib[2] = 4'd15;
      tick();
    end
    iv[1] = 1'b0; iv[2] = 1'b0;
    chk("sat_res", 32'(res[1]), 1023);
    chk("sat_ovf", 32'(ovf[1]), 1);
    chk("wrap_res", 32'(res[2]), 776);
    chk("wrap_ovf", 32'(ovf[2]), 1);
    tick();
    iv[1] = 1'b1; ia[1] = 4'd1; ib[1] = 4'd1;
    iv[2] = 1'b1; ia[2] = 4'd1; ib[2] = 4'd1;
    tick();
    iv[1] = 1'b0; iv[2] = 1'b0;
    chk("sat_next_ovf", 32'(ovf[1]), 0);
    chk("wrap_next_ovf", 32'(ovf[2]), 0);
    chk("sat_next_res", 32'(res[1]), 1);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 2) != 0);
        clr[k]  = ($urandom_range(0, 40) == 0);
        if (k > 0 && $urandom_range(0, 1) == 1) begin
          ia[k] = 4'($urandom_range(12, 15));
          ib[k] = 4'($urandom_range(12, 15));
        end else begin
          ia[k] = 4'($urandom);
          ib[k] = 4'($urandom);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
